// File: rtl/accum_unpacker.sv
// Serialises a packed 4-lane accumulator result into W-bit beats (4/2/1 by mode).
// Define ACC_UNPACK_PIPE_EN to reload on the last beat for bubble-free packets.
module accum_unpacker #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   in_mode,
    input  logic [4*W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   out_idx,
    output logic         out_last,
    output logic         err
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t         state, state_n;
    logic [4*W-1:0] data_q, data_n;
    logic [1:0]     idx_q, idx_n;
    logic [1:0]     last_idx_q, last_idx_n;
    logic           err_n;
    logic           accept, fire, is_last, illegal;
    logic [1:0]     lane;
    logic [1:0]     mode_last;

    assign is_last   = (state == SEND) && (idx_q == last_idx_q);
    assign out_valid = (state == SEND);
    assign out_idx   = idx_q;
    assign out_last  = is_last;
    assign lane      = last_idx_q - idx_q;
    assign out_data  = data_q[lane*W +: W];

`ifdef ACC_UNPACK_PIPE_EN
    assign in_ready = !rst && ((state == IDLE) || (is_last && out_ready));
`else
    assign in_ready = !rst && (state == IDLE);
`endif

    assign accept  = in_valid && in_ready;
    assign fire    = out_valid && out_ready;
    assign illegal = (in_mode == 2'b10);

    // Highest beat index for the incoming mode; mode 10 never reaches SEND
    always_comb begin
        mode_last = 2'd0;
        unique case (in_mode)
            2'b00:   mode_last = 2'd3;
            2'b01:   mode_last = 2'd1;
            default: mode_last = 2'd0;
        endcase
    end

    always_comb begin
        state_n    = state;
        data_n     = data_q;
        idx_n      = idx_q;
        last_idx_n = last_idx_q;
        err_n      = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (illegal) begin
                        err_n = 1'b1;
                    end else begin
                        data_n     = in_data;
                        last_idx_n = mode_last;
                        idx_n      = 2'd0;
                        state_n    = SEND;
                    end
                end
            end
            SEND: begin
                if (fire) begin
                    if (!is_last) begin
                        idx_n = idx_q + 2'd1;
                    end else begin
                        state_n = IDLE;
`ifdef ACC_UNPACK_PIPE_EN
                        if (accept) begin
                            if (illegal) begin
                                err_n = 1'b1;
                            end else begin
                                data_n     = in_data;
                                last_idx_n = mode_last;
                                idx_n      = 2'd0;
                                state_n    = SEND;
                            end
                        end
`endif
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            data_q     <= '0;
            idx_q      <= 2'd0;
            last_idx_q <= 2'd0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            data_q     <= data_n;
            idx_q      <= idx_n;
            last_idx_q <= last_idx_n;
            err        <= err_n;
        end
    end

endmodule

// File: tb/tb_accum_unpacker.sv
// Directed bench for accum_unpacker: ordering, stalls, illegal mode, back-to-back, reset.
module tb_accum_unpacker;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_mode;
    logic [4*W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   out_idx;
    logic         out_last;
    logic         err;

    int checks   = 0;
    int failures = 0;

    accum_unpacker #(.W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_mode  (in_mode),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_idx  (out_idx),
        .out_last (out_last),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input string tag, input logic [15:0] d, input logic [1:0] i, input logic l);
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_data"}, 64'(out_data), 64'(d));
        chk({tag, "_idx"}, 64'(out_idx), 64'(i));
        chk({tag, "_last"}, 64'(out_last), 64'(l));
        chk({tag, "_inrdy"}, 64'(in_ready), 64'd0);
    endtask

    task automatic offer(input logic [1:0] m, input logic [63:0] d);
        in_valid = 1'b1;
        in_mode  = m;
        in_data  = d;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mode   = 2'b00;
        in_data   = '0;
        out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_inrdy", 64'(in_ready), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_idx", 64'(out_idx), 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_inrdy", 64'(in_ready), 64'd1);

        // Mode 00: four lanes, high lane first
        offer(2'b00, 64'h1111_2222_3333_4444);
        @(negedge clk);
        in_valid = 1'b0;
        beat("m0_b0", 16'h1111, 2'd0, 1'b0);
        @(negedge clk);
        beat("m0_b1", 16'h2222, 2'd1, 1'b0);
        @(negedge clk);
        beat("m0_b2", 16'h3333, 2'd2, 1'b0);
        @(negedge clk);
        beat("m0_b3", 16'h4444, 2'd3, 1'b1);
        @(negedge clk);
        chk("m0_end_valid", 64'(out_valid), 64'd0);
        chk("m0_end_inrdy", 64'(in_ready), 64'd1);

        // Mode 01: two partial sums, upper lanes ignored
        offer(2'b01, 64'hDEAD_BEEF_0005_0007);
        @(negedge clk);
        in_valid = 1'b0;
        beat("m1_b0", 16'h0005, 2'd0, 1'b0);
        @(negedge clk);
        beat("m1_b1", 16'h0007, 2'd1, 1'b1);
        @(negedge clk);
        chk("m1_end_valid", 64'(out_valid), 64'd0);

        // Mode 11: single final sum
        offer(2'b11, 64'hABCD_1234_5678_00FF);
        @(negedge clk);
        in_valid = 1'b0;
        beat("m3_b0", 16'h00FF, 2'd0, 1'b1);
        @(negedge clk);
        chk("m3_end_valid", 64'(out_valid), 64'd0);

        // Mode 00 with downstream stalls
        offer(2'b00, 64'hAAAA_BBBB_CCCC_DDDD);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        beat("st_a0", 16'hAAAA, 2'd0, 1'b0);
        @(negedge clk);
        beat("st_a1", 16'hAAAA, 2'd0, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        beat("st_b0", 16'hBBBB, 2'd1, 1'b0);
        out_ready = 1'b0;
        @(negedge clk);
        beat("st_b1", 16'hBBBB, 2'd1, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        beat("st_c", 16'hCCCC, 2'd2, 1'b0);
        @(negedge clk);
        out_ready = 1'b0;
        beat("st_d0", 16'hDDDD, 2'd3, 1'b1);
        @(negedge clk);
        beat("st_d1", 16'hDDDD, 2'd3, 1'b1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("st_end_valid", 64'(out_valid), 64'd0);

        // Illegal mode, then legal packet on the next cycle
        offer(2'b10, 64'h9999_9999_9999_9999);
        @(negedge clk);
        chk("il_err", 64'(err), 64'd1);
        chk("il_valid", 64'(out_valid), 64'd0);
        chk("il_inrdy", 64'(in_ready), 64'd1);
        offer(2'b11, 64'h0000_0000_0000_1234);
        @(negedge clk);
        in_valid = 1'b0;
        chk("il_err_clr", 64'(err), 64'd0);
        beat("il_next", 16'h1234, 2'd0, 1'b1);
        @(negedge clk);

        // Back-to-back illegal words pulse err on consecutive cycles
        offer(2'b10, 64'h1);
        @(negedge clk);
        chk("il2_err0", 64'(err), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("il2_err1", 64'(err), 64'd1);
        @(negedge clk);
        chk("il2_err2", 64'(err), 64'd0);
        chk("il2_valid", 64'(out_valid), 64'd0);

        // Two mode-11 packets back-to-back
        offer(2'b11, 64'h0001);
        @(negedge clk);
        chk("bb_p1_data", 64'(out_data), 64'h0001);
        chk("bb_p1_valid", 64'(out_valid), 64'd1);
        offer(2'b11, 64'h0002);
`ifdef ACC_UNPACK_PIPE_EN
        chk("bb_p1_inrdy", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bb_p2_valid", 64'(out_valid), 64'd1);
        chk("bb_p2_data", 64'(out_data), 64'h0002);
`else
        chk("bb_p1_inrdy", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("bb_gap_valid", 64'(out_valid), 64'd0);
        chk("bb_gap_inrdy", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bb_p2_valid", 64'(out_valid), 64'd1);
        chk("bb_p2_data", 64'(out_data), 64'h0002);
`endif
        @(negedge clk);
        chk("bb_end_valid", 64'(out_valid), 64'd0);

        // Reset during beat 2 of a mode-00 packet
        offer(2'b00, 64'h5555_6666_7777_8888);
        @(negedge clk);
        in_valid = 1'b0;
        beat("rs_b0", 16'h5555, 2'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        beat("rs_b2", 16'h7777, 2'd2, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        chk("rs_async_valid", 64'(out_valid), 64'd0);
        chk("rs_async_inrdy", 64'(in_ready), 64'd0);
        chk("rs_async_idx", 64'(out_idx), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rs_after_valid", 64'(out_valid), 64'd0);
        offer(2'b01, 64'h0000_0000_0009_000A);
        @(negedge clk);
        in_valid = 1'b0;
        beat("rs_n0", 16'h0009, 2'd0, 1'b0);
        @(negedge clk);
        beat("rs_n1", 16'h000A, 2'd1, 1'b1);
        @(negedge clk);
        chk("rs_end_valid", 64'(out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/accum_unpacker.md
# accum_unpacker

Reader-side counterpart to the four-lane accumulator: accepts one packed 64-bit result word plus its 2-bit reduction mode and emits it as a stream of 16-bit words over a valid/ready handshake. The mode sets the word count: 4 raw lanes, 2 partial sums or 1 final sum. The block sits between the accumulator output and the downstream 16-bit writeback/serial path, so the datapath runs at the narrower width.

## Interface
Parameters:
- `W`, 16, lane width; packed input is `4*W` bits.

Ports:
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — asynchronous, active-high reset.
- `in_valid` in 1 — packed word present.
- `in_ready` out 1 — block accepts packed word this cycle.
- `in_mode` in 2 — 00: four lanes, 01: two sums, 11: one sum, 10: illegal.
- `in_data` in 4*W — packed word; lane3 = [4W-1:3W] … lane0 = [W-1:0].
- `out_valid` out 1 — output word valid.
- `out_ready` in 1 — downstream accepts.
- `out_data` out W — current word.
- `out_idx` out 2 — beat index within packet, 0-based.
- `out_last` out 1 — final beat of packet.
- `err` out 1 — one-cycle pulse on illegal mode accept.

## Operation
- States: IDLE, SEND.
- IDLE: `in_ready`=1. Transfer on `in_valid & in_ready`.
  - Legal mode: capture data, mode; beat count = 4/2/1; `idx`=0; go to SEND.
  - Mode 10: discard data, pulse `err` next cycle, stay IDLE.
- SEND: `out_valid`=1.
  - `out_data` order: mode 00 → lane3, lane2, lane1, lane0. Mode 01 → lane1, lane0. Mode 11 → lane0 only.
  - `out_last`=1 on the final beat (`idx`=count-1).
  - On `out_valid & out_ready`: non-last beat → `idx`+1. Last beat → IDLE, unless the pipelined reload fires (see Configuration).
- While `out_valid & !out_ready`, `out_data`/`out_idx`/`out_last` hold stable.
- No arithmetic; pure selection. Upper unused lanes in modes 01/11 are ignored, never emitted.

## Timing
- Reset (async, immediate): state IDLE; `out_valid`=0, `out_data`=0, `out_idx`=0, `out_last`=0, `err`=0. `in_ready` is forced 0 while `rst` is high.
- Latency: packed word accepted on edge N → first `out_valid` cycle N+1 (registered outputs).
- Throughput, `out_ready` held 1, no macro: an n-beat packet occupies n SEND cycles plus 1 IDLE cycle.
- `err` is high exactly one cycle after the illegal accept. `in_ready` stays 1 across it, so back-to-back illegal words pulse on consecutive cycles.
- Reset mid-packet: remaining beats are dropped. `out_valid` falls asynchronously and nothing is resumed after release.
- `in_valid` in SEND (no macro): ignored. The upstream must hold it, since `in_ready`=0.

## Configuration
- `ACC_UNPACK_PIPE_EN` defined:
  - `in_ready` = IDLE | (SEND & `out_last` & `out_ready`). Combinational path from `out_ready` to `in_ready`.
  - A transfer on the last beat reloads the new packet directly and stays in SEND, giving zero bubbles between packets.
  - An illegal mode during reload pulses `err` and goes to IDLE.
- Not defined: `in_ready` = IDLE only, with no combinational path from `out_ready`. One bubble per packet.

## Test plan
- Mode 00, `in_data`=0x1111_2222_3333_4444, `out_ready`=1 → beats 0x1111, 0x2222, 0x3333, 0x4444. `idx` 0..3, `out_last` on 0x4444, first beat one cycle after accept.
- Mode 01, data 0xDEAD_BEEF_0005_0007 → beats 0x0005, 0x0007 only. Mode 11 with 0x…_00FF → single beat 0x00FF with `out_last`=1.
- Mode 00, `out_ready` toggled 1,0,0,1,… → each word held stable while stalled, no beat lost or duplicated, `in_ready`=0 throughout SEND.
- Mode 10 accepted → no `out_valid`, `err`=1 for exactly one cycle. A following legal packet is accepted the next cycle.
- Two mode-11 packets back-to-back, `out_ready`=1 → gap of 1 cycle without `ACC_UNPACK_PIPE_EN`, consecutive beats with it.
- Assert `rst` during beat 2 of a mode-00 packet → `out_valid`=0 immediately, and after release the first output is from the next accepted packet.
